xs3_bcd_serial_conv: RTL and testbench

XS3_BCD_SERIAL_CONV -- requirements
Module: xs3_bcd_serial_conv

---
 rtl/xs3_bcd_serial_conv.sv | 161 ++++++++++++++++
 tb/tb_xs3_bcd_serial_conv.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xs3_bcd_serial_conv.sv
// xs3_bcd_serial_conv
// Serial excess-3 to BCD word converter. A word of DIGITS excess-3 nibbles
// is accepted, converted one nibble per clock (digit 0 first), and the BCD
// result is presented until the consumer takes it.
//
// Optional feature macro: XS3_ERR_CHECK_EN
//   defined   -> each converted nibble outside 0x3..0xC sets err, and err_idx
//                records the lowest-numbered such digit.
//   undefined -> err and err_idx are tied to 0 and no range check exists.
//
// Handshake (both sides): a beat transfers on a rising clk edge where
// valid=1 and ready=1. The producer holds data stable while valid=1 and
// ready=0; out_bcd/err/err_idx are held stable while out_valid=1 and
// out_ready=0. in_ready depends combinationally on out_ready in DONE so a
// new word can be accepted on the same edge the result is taken.

module xs3_bcd_serial_conv #(
    parameter int  DIGITS = 4,
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_xs3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  err,
    output logic [IDX_W-1:0]      err_idx,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   word_q, word_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;

    logic                  load;
    logic [3:0]            cur_xs3;

    // Accept in IDLE, or in DONE when the result is taken on the same edge.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign load      = in_valid && in_ready;
    assign cur_xs3   = word_q[cnt_q*4 +: 4];

    assign out_valid = out_valid_q;
    assign out_bcd   = bcd_q;
    assign dbg_state = state_q;

    // Next-state and datapath: load on accept, one nibble per CONV cycle.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    word_d  = in_xs3;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                // Modulo-16 subtraction: out-of-range digits still produce a nibble.
                bcd_d[cnt_q*4 +: 4] = cur_xs3 - 4'd3;
                if (cnt_q == LAST_IDX) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (load) begin
                        word_d  = in_xs3;
                        bcd_d   = '0;
                        cnt_d   = '0;
                        state_d = CONV;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef XS3_ERR_CHECK_EN
    logic             err_q, err_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic             digit_bad;

    assign digit_bad = (cur_xs3 < 4'h3) || (cur_xs3 > 4'hC);
    assign err       = err_q;
    assign err_idx   = err_idx_q;

    // First invalid digit wins: later bad digits never overwrite err_idx.
    always_comb begin
        err_d     = err_q;
        err_idx_d = err_idx_q;
        if (load) begin
            err_d     = 1'b0;
            err_idx_d = '0;
        end else if ((state_q == CONV) && digit_bad && !err_q) begin
            err_d     = 1'b1;
            err_idx_d = cnt_q;
        end
    end

    // Error flag and index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end
`else
    assign err     = 1'b0;
    assign err_idx = '0;
`endif

endmodule

// File: tb/tb_xs3_bcd_serial_conv.sv
// Directed bench for xs3_bcd_serial_conv: a DIGITS=4 instance driven from a
// vector table plus hand-written backpressure / reset sequences, and a
// DIGITS=1 instance for the single-digit build.
module tb_xs3_bcd_serial_conv;

  localparam int DIGITS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT, DIGITS=4 ----------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_xs3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_bcd;
  logic        err;
  logic [1:0]  err_idx;
  logic [1:0]  dbg_state;

  xs3_bcd_serial_conv #(.DIGITS(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_xs3(in_xs3),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
    .err(err), .err_idx(err_idx), .dbg_state(dbg_state)
  );

  // ---------------- DUT, DIGITS=1 ----------------
  logic       d1_in_valid = 1'b0;
  logic       d1_in_ready;
  logic [3:0] d1_in_xs3 = '0;
  logic       d1_out_valid;
  logic       d1_out_ready = 1'b1;
  logic [3:0] d1_out_bcd;
  logic       d1_err;
  logic [0:0] d1_err_idx;
  logic [1:0] d1_dbg_state;

  xs3_bcd_serial_conv #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_xs3(d1_in_xs3),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_bcd(d1_out_bcd),
    .err(d1_err), .err_idx(d1_err_idx), .dbg_state(d1_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Count edges after an accept until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  // Accept one word (in_ready must already be 1), then check latency and result.
  task automatic run_vec(input logic [15:0] xs3, input logic [15:0] eb,
                         input logic ee, input logic [1:0] ei, input string name);
    int lat;
    logic [15:0] exp_bcd;
    check({"in_ready_", name}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_xs3   = xs3;
    exp_q.push_back(eb);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_xs3   = '0;
    check({"busy_", name}, 32'(in_ready), 32'd0);
    wait_out(lat);
    check({"lat_", name}, 32'(lat), 32'(DIGITS));
    exp_bcd = exp_q.pop_front();
    check({"valid_", name}, 32'(out_valid), 32'd1);
    check({"bcd_", name}, 32'(out_bcd), 32'(exp_bcd));
    check({"err_", name}, 32'(err), 32'(ee));
    check({"idx_", name}, 32'(err_idx), 32'(ei));
  endtask

  // ---------------- vector table ----------------
  // err/idx columns hold the values with range checking enabled; the
  // default build expects 0 for both.
  typedef struct {
    logic [15:0] xs3;
    logic [15:0] bcd;
    logic        err;
    logic [1:0]  idx;
    string       name;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat;
    bit seen;
    logic ee;
    logic [1:0] ei;

    vecs[0] = '{16'h4B73, 16'h1840, 1'b0, 2'd0, "basic"};
    vecs[1] = '{16'h3333, 16'h0000, 1'b0, 2'd0, "all3"};
    vecs[2] = '{16'hCCCC, 16'h9999, 1'b0, 2'd0, "allC"};
    vecs[3] = '{16'h6A58, 16'h3725, 1'b0, 2'd0, "mix"};
    // Digit 0 is 0x3 (valid); digit 1 is 0x1, the lowest invalid digit.
    vecs[4] = '{16'h4F13, 16'h1CE0, 1'b1, 2'd1, "bad_4F13"};
    vecs[5] = '{16'h5C39, 16'h2906, 1'b0, 2'd0, "mix2"};
    vecs[6] = '{16'h0000, 16'hDDDD, 1'b1, 2'd0, "all0"};
    vecs[7] = '{16'hFFFF, 16'hCCCC, 1'b1, 2'd0, "allF"};
    vecs[8] = '{16'hE333, 16'hB000, 1'b1, 2'd3, "bad_top"};

    // Async reset: outputs must clear before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'(out_bcd), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_idx", 32'(err_idx), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Table: first entry accepted on first edge after reset release,
    // remaining entries back-to-back from DONE with out_ready=1.
    for (int i = 0; i < 9; i++) begin
`ifdef XS3_ERR_CHECK_EN
      ee = vecs[i].err;
      ei = vecs[i].idx;
`else
      ee = 1'b0;
      ei = 2'd0;
`endif
      run_vec(vecs[i].xs3, vecs[i].bcd, ee, ei, vecs[i].name);
    end

    // Drain to IDLE.
    @(posedge clk); #1;
    check("drain_idle", 32'(dbg_state), 32'd0);

    // Backpressure: in_valid held high throughout CONV/DONE with a different
    // word, which must be ignored until the result is taken.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_xs3    = 16'h4B73;
    @(posedge clk); #1;
    in_xs3 = 16'h5555;
    wait_out(lat);
    check("bp_lat", 32'(lat), 32'd4);
    check("bp_bcd", 32'(out_bcd), 32'h1840);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_bcd", 32'(out_bcd), 32'h1840);
      check("bp_hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_xs3   = '0;
    check("b2b_conv", 32'(dbg_state), 32'd1);
    check("b2b_valid_low", 32'(out_valid), 32'd0);
    wait_out(lat);
    check("b2b_lat", 32'(lat), 32'd4);
    check("b2b_bcd", 32'(out_bcd), 32'h2222);
    @(posedge clk); #1;

    // Reset two cycles into a conversion (digits 0,1 already written).
    in_valid = 1'b1;
    in_xs3   = 16'h4B73;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_bcd", 32'(out_bcd), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);

    // Reset while holding a finished result in DONE.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_xs3    = 16'h3333;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    check("donerst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("donerst_valid", 32'(out_valid), 32'd0);
    check("donerst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("donerst_no_valid", 32'(seen), 32'd0);

    // DIGITS=1 instance: one-cycle conversion.
    d1_in_valid = 1'b1;
    d1_in_xs3   = 4'hC;
    @(posedge clk); #1;
    d1_in_valid = 1'b0;
    check("d1_conv_valid", 32'(d1_out_valid), 32'd0);
    @(posedge clk); #1;
    check("d1_valid", 32'(d1_out_valid), 32'd1);
    check("d1_bcd_C", 32'(d1_out_bcd), 32'h9);
    d1_in_valid = 1'b1;
    d1_in_xs3   = 4'h2;
    @(posedge clk); #1;
    d1_in_valid = 1'b0;
    @(posedge clk); #1;
    check("d1_valid_2", 32'(d1_out_valid), 32'd1);
    check("d1_bcd_2", 32'(d1_out_bcd), 32'hF);
`ifdef XS3_ERR_CHECK_EN
    check("d1_err_2", 32'(d1_err), 32'd1);
`else
    check("d1_err_2", 32'(d1_err), 32'd0);
`endif
    check("d1_idx_2", 32'(d1_err_idx), 32'd0);
    @(posedge clk); #1;
    check("d1_idle", 32'(d1_dbg_state), 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
